// File: rtl/window_fetcher.sv
// 3x3 neighbourhood fetcher: reads each pixel's window from a fixed-latency memory
// in raster order with edge replication, and presents it on a valid/ready handshake.
module window_fetcher #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned IMG_WIDTH   = 512,
    parameter int unsigned IMG_HEIGHT  = 512,
    parameter int unsigned COORD_WIDTH = 10,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                    Win_CLK,
    input  logic                    Win_RST,
    input  logic                    Win_START,
    output logic                    Win_BUSY,
    output logic                    Win_DONE,
    output logic [1:0]              Win_MEM_RW,
    output logic [ADDR_WIDTH-1:0]   Win_MEM_ADDR,
    input  logic [DATA_WIDTH-1:0]   Win_MEM_ODR,
    output logic                    Win_WVALID,
    input  logic                    Win_WREADY,
    output logic [9*DATA_WIDTH-1:0] Win_WINDOW,
    output logic [COORD_WIDTH-1:0]  Win_X,
    output logic [COORD_WIDTH-1:0]  Win_Y
);

    localparam int unsigned TAG_WIDTH = 4;
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMG_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [TAG_WIDTH-1:0]   K_LAST = TAG_WIDTH'(8);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, VALID, FIN} state_t;

    state_t                 state, state_n;
    logic [COORD_WIDTH-1:0] x_n, y_n;
    logic [TAG_WIDTH-1:0]   k, k_n;
    logic                   rd_n, wvalid_n, done_n;
    logic [1:0]             row_sel, col_sel;
    logic [COORD_WIDTH-1:0] cx, cy;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic                   p0_valid, p1_valid;
    logic [TAG_WIDTH-1:0]   p0_tag, p1_tag;

    // Next-state and next-output logic; k_n is the request index issued next cycle.
    always_comb begin
        state_n  = state;
        x_n      = Win_X;
        y_n      = Win_Y;
        k_n      = k;
        rd_n     = 1'b0;
        wvalid_n = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (Win_START) begin
                    x_n     = '0;
                    y_n     = '0;
                    k_n     = '0;
                    rd_n    = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (k == K_LAST) begin
                    state_n = DRAIN;
                end else begin
                    k_n  = k + TAG_WIDTH'(1);
                    rd_n = 1'b1;
                end
            end
            DRAIN: begin
                wvalid_n = 1'b1;
                state_n  = VALID;
            end
            VALID: begin
                wvalid_n = 1'b1;
                if (Win_WREADY) begin
                    wvalid_n = 1'b0;
                    k_n      = '0;
                    if (Win_X == X_LAST && Win_Y == Y_LAST) begin
                        done_n  = 1'b1;
                        state_n = FIN;
                    end else begin
                        rd_n    = 1'b1;
                        state_n = FETCH;
                        if (Win_X == X_LAST) begin
                            x_n = '0;
                            y_n = Win_Y + COORD_WIDTH'(1);
                        end else begin
                            x_n = Win_X + COORD_WIDTH'(1);
                        end
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Clamped neighbour coordinate and address for the request about to be issued.
    always_comb begin
        row_sel = (k_n >= TAG_WIDTH'(6)) ? 2'd2 : (k_n >= TAG_WIDTH'(3)) ? 2'd1 : 2'd0;
        col_sel = 2'(k_n - TAG_WIDTH'(row_sel) * TAG_WIDTH'(3));
        unique case (col_sel)
            2'd0:    cx = (x_n == '0) ? '0 : x_n - COORD_WIDTH'(1);
            2'd2:    cx = (x_n == X_LAST) ? x_n : x_n + COORD_WIDTH'(1);
            default: cx = x_n;
        endcase
        unique case (row_sel)
            2'd0:    cy = (y_n == '0) ? '0 : y_n - COORD_WIDTH'(1);
            2'd2:    cy = (y_n == Y_LAST) ? y_n : y_n + COORD_WIDTH'(1);
            default: cy = y_n;
        endcase
        addr_n = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cy) * ADDR_WIDTH'(IMG_WIDTH)
               + ADDR_WIDTH'(cx);
    end

    always_ff @(posedge Win_CLK or posedge Win_RST) begin
        if (Win_RST) begin
            state        <= IDLE;
            k            <= '0;
            Win_X        <= '0;
            Win_Y        <= '0;
            Win_MEM_RW   <= 2'b00;
            Win_MEM_ADDR <= '0;
            Win_WVALID   <= 1'b0;
            Win_DONE     <= 1'b0;
            Win_BUSY     <= 1'b0;
        end else begin
            state        <= state_n;
            k            <= k_n;
            Win_X        <= x_n;
            Win_Y        <= y_n;
            Win_MEM_RW   <= rd_n ? 2'b10 : 2'b00;
            if (rd_n) begin
                Win_MEM_ADDR <= addr_n;
            end
            Win_WVALID   <= wvalid_n;
            Win_DONE     <= done_n;
            Win_BUSY     <= (state_n != IDLE);
        end
    end

    // Two-stage tag pipeline matching the memory's read latency; stage 1 writes the slot.
    always_ff @(posedge Win_CLK or posedge Win_RST) begin
        if (Win_RST) begin
            p0_valid   <= 1'b0;
            p0_tag     <= '0;
            p1_valid   <= 1'b0;
            p1_tag     <= '0;
            Win_WINDOW <= '0;
        end else begin
            p0_valid <= rd_n;
            p0_tag   <= k_n;
            p1_valid <= p0_valid;
            p1_tag   <= p0_tag;
            if (p1_valid) begin
                Win_WINDOW[int'(p1_tag)*DATA_WIDTH +: DATA_WIDTH] <= Win_MEM_ODR;
            end
        end
    end

endmodule

// File: tb/tb_window_fetcher.sv
// Bench for window_fetcher on a 4x4 image whose pixel values equal their addresses.
module tb_window_fetcher;

    localparam int DW = 24;
    localparam int AW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 10;

    localparam logic [9*DW-1:0] W00 = {24'd5, 24'd4, 24'd4, 24'd1, 24'd0, 24'd0, 24'd1, 24'd0, 24'd0};
    localparam logic [9*DW-1:0] W11 = {24'd10, 24'd9, 24'd8, 24'd6, 24'd5, 24'd4, 24'd2, 24'd1, 24'd0};
    localparam logic [9*DW-1:0] W33 = {24'd15, 24'd15, 24'd14, 24'd15, 24'd15, 24'd14, 24'd11, 24'd11, 24'd10};

    logic           clk = 1'b0;
    logic           rst, start, wready;
    logic           busy, done, wvalid;
    logic [1:0]     rw;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  odr;
    logic [9*DW-1:0] window;
    logic [CW-1:0]  wx, wy;

    typedef struct packed {
        logic [9*DW-1:0] w;
        logic [CW-1:0]   x;
        logic [CW-1:0]   y;
    } ewin_t;

    ewin_t          q_win[$];
    logic [AW-1:0]  q_addr[$];
    int total = 0, bad = 0;
    int reads = 0, hs = 0, dones = 0, illegal = 0, cyc = 0, last_hs = -1;
    bit gap_en = 1'b0;

    window_fetcher #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .COORD_WIDTH(CW), .BASE_ADDR(0)
    ) dut (
        .Win_CLK(clk), .Win_RST(rst), .Win_START(start), .Win_BUSY(busy),
        .Win_DONE(done), .Win_MEM_RW(rw), .Win_MEM_ADDR(addr), .Win_MEM_ODR(odr),
        .Win_WVALID(wvalid), .Win_WREADY(wready), .Win_WINDOW(window),
        .Win_X(wx), .Win_Y(wy)
    );

    always #5 clk = ~clk;

    // Memory: 2-cycle read latency, contents equal to the address.
    always @(posedge clk) begin
        if (rw == 2'b10) odr <= DW'(addr);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic int pix_addr(input int x, input int y, input int k);
        return clampi(y + k / 3 - 1, H - 1) * W + clampi(x + k % 3 - 1, W - 1);
    endfunction

    function automatic logic [9*DW-1:0] model_win(input int x, input int y);
        logic [9*DW-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*DW +: DW] = DW'(pix_addr(x, y, k));
        return r;
    endfunction

    task automatic push_expect();
        ewin_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.w = model_win(x, y);
                e.x = CW'(x);
                e.y = CW'(y);
                q_win.push_back(e);
                for (int k = 0; k < 9; k++) q_addr.push_back(AW'(pix_addr(x, y, k)));
            end
        end
    endtask

    // Per-cycle comparison of bus traffic and presented windows against the model.
    always @(negedge clk) begin
        ewin_t e;
        cyc++;
        if (!rst) begin
            if (rw == 2'b01) illegal++;
            if (rw == 2'b10) begin
                reads++;
                if (q_addr.size() == 0) fail("rd_extra");
                else check("rd_addr", addr, q_addr.pop_front());
            end
            if (wvalid) begin
                if (q_win.size() == 0) begin
                    fail("win_extra");
                end else begin
                    e = q_win[0];
                    check("win", window, e.w);
                    check("win_x", wx, e.x);
                    check("win_y", wy, e.y);
                    check("rw_in_valid", rw, 2'b00);
                    if (wx == 0 && wy == 0) check("win00_lit", window, W00);
                    if (wx == 1 && wy == 1) check("win11_lit", window, W11);
                    if (wx == 3 && wy == 3) check("win33_lit", window, W33);
                    if (wready) begin
                        void'(q_win.pop_front());
                        hs++;
                        if (gap_en && last_hs >= 0) check("hs_gap", cyc - last_hs, 11);
                        last_hs = cyc;
                    end
                end
            end
            if (done) begin
                dones++;
                check("done_all_seen", q_win.size(), 0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (wvalid) break;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            fail(name);
        end else begin
            @(posedge clk); #1;
            check({name, "_done_pulse"}, done, 1'b0);
            check({name, "_busy_drop"}, busy, 1'b0);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_rw"}, rw, 2'b00);
        check({name, "_addr"}, addr, 0);
        check({name, "_wvalid"}, wvalid, 1'b0);
        check({name, "_window"}, window, 0);
        check({name, "_x"}, wx, 0);
        check({name, "_y"}, wy, 0);
    endtask

    task automatic check_pass(input string name, input int r0, input int h0, input int d0);
        check({name, "_reads"}, reads - r0, 144);
        check({name, "_windows"}, hs - h0, 16);
        check({name, "_dones"}, dones - d0, 1);
        check({name, "_rd_left"}, q_addr.size(), 0);
    endtask

    initial begin
        int lat, r0, h0, d0;
        rst = 1'b1;
        start = 1'b0;
        wready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full pass with WREADY held high and a stray START mid-pass.
        wready = 1'b1;
        gap_en = 1'b1;
        last_hs = -1;
        r0 = reads; h0 = hs; d0 = dones;
        push_expect();
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        wait_valid(lat);
        check("latency1", lat, 10);
        repeat (20) @(posedge clk);
        #1;
        pulse_start();
        wait_done("pass1");
        check_pass("pass1", r0, h0, d0);
        gap_en = 1'b0;

        // Backpressure on the first window.
        wready = 1'b0;
        r0 = reads; h0 = hs; d0 = dones;
        push_expect();
        pulse_start();
        wait_valid(lat);
        check("latency2", lat, 10);
        for (int i = 0; i < 5; i++) begin
            check("hold_window", window, W00);
            check("hold_x", wx, 0);
            check("hold_y", wy, 0);
            check("hold_rw", rw, 2'b00);
            check("hold_wvalid", wvalid, 1'b1);
            @(posedge clk); #1;
        end
        wready = 1'b1;
        wait_done("pass2");
        check_pass("pass2", r0, h0, d0);

        // Reset in FETCH cycle 4, then a clean restart.
        push_expect();
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check("fetch4_rw", rw, 2'b10);
        check("fetch4_addr", addr, 0);
        rst = 1'b1;
        #1;
        check_idle("midreset");
        q_addr.delete();
        q_win.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("no_done_after_reset", dones - d0, 1);
        r0 = reads; h0 = hs; d0 = dones;
        push_expect();
        pulse_start();
        wait_valid(lat);
        check("latency3", lat, 10);
        check("restart_x", wx, 0);
        check("restart_y", wy, 0);
        wait_done("pass3");
        check_pass("pass3", r0, h0, d0);

        check("rw_never_01", illegal, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
